// File: rtl/unpacker_arb.sv
// unpacker_arb: packet-level round-robin arbiter sharing one unpacker_fsm input among N_PORTS sources
//   clk, reset_L             : clock, asynchronous active-low reset
//   in_val/sop/eop/vbc/data  : per-port upstream beats, in_ready per-port accept
//   cfg_port_en              : per-port enable, consulted only when a new grant is made
//   val/sop/eop/vbc/data     : beat to the unpacker, ready is its accept
//   grant/idle/err           : one-hot owner, no packet in progress, protocol violation pulse
module unpacker_arb #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 1280,
  parameter int VBC_W   = 8,
  parameter int MAX_VBC = 160
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [N_PORTS-1:0]        in_val,
  input  logic [N_PORTS-1:0]        in_sop,
  input  logic [N_PORTS-1:0]        in_eop,
  input  logic [N_PORTS*VBC_W-1:0]  in_vbc,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  output logic [N_PORTS-1:0]        in_ready,
  input  logic [N_PORTS-1:0]        cfg_port_en,
  output logic                      val,
  output logic                      sop,
  output logic                      eop,
  output logic [VBC_W-1:0]          vbc,
  output logic [DATA_W-1:0]         data,
  input  logic                      ready,
  output logic [N_PORTS-1:0]        grant,
  output logic                      idle,
  output logic                      err
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [VBC_W-1:0] MAXV = VBC_W'(MAX_VBC);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state;
  logic [N_PORTS-1:0] grant_q, grant_d, elig;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, owner;
  logic [PW:0] idx;
  logic err_q, err_d, first_q, first_d, xfer, bad, found;
  // the grant register doubles as the FSM state: nonzero means a packet is in progress
  assign state = |grant_q ? BUSY : IDLE;
  assign elig = cfg_port_en & in_val & in_sop;
  assign in_ready = grant_q & {N_PORTS{ready}};
  assign grant = grant_q;
  assign idle = ~|grant_q;
  assign err = err_q;
  assign xfer = val & ready;
  assign bad = (sop & ~first_q) | (vbc == '0) | (vbc > MAXV) | (~eop & (vbc != MAXV));
  // grant is one-hot, so at most one iteration drives the outputs; all zero when idle
  always_comb begin
    owner = '0;
    val = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
    vbc = '0;
    data = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (grant_q[i]) begin
        owner = PW'(i);
        val = in_val[i];
        sop = in_sop[i];
        eop = in_eop[i];
        vbc = in_vbc[i*VBC_W +: VBC_W];
        data = in_data[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    first_d = first_q;
    err_d = 1'b0;
    found = 1'b0;
    idx = '0;
    if (state == IDLE) begin
      first_d = 1'b1;
      // scan upward from rr_ptr, wrapping, and take the first eligible port
      for (int k = 0; k < N_PORTS; k++) begin
        idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
        idx = (idx >= (PW+1)'(N_PORTS)) ? idx - (PW+1)'(N_PORTS) : idx;
        if (!found && elig[idx[PW-1:0]]) begin
          found = 1'b1;
          grant_d = '0;
          grant_d[idx[PW-1:0]] = 1'b1;
        end
      end
    end else if (xfer) begin
      err_d = bad;
      first_d = 1'b0;
      if (eop) begin
        grant_d = '0;
        rr_ptr_d = (owner == PW'(N_PORTS-1)) ? '0 : owner + PW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      grant_q <= '0;
      rr_ptr_q <= '0;
      err_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q <= err_d;
      first_q <= first_d;
    end
endmodule

// File: doc/unpacker_arb.md
# unpacker_arb

Packet-level round-robin arbiter that shares one `unpacker_fsm` input port among N_PORTS upstream packet sources. It grants one source from sop to eop, forwards that source's 160-byte beats with the val/ready handshake, and rotates priority after each completed packet. Sits directly in front of `unpacker_fsm`; its downstream side connects to the unpacker's val/sop/eop/vbc/data/ready port.

## Interface
- N_PORTS, 4, number of requesters (2..8)
- DATA_W, 1280, beat width in bits (160 B)
- VBC_W, 8, valid-byte-count width
- MAX_VBC, 160, largest legal vbc
- clk  in  1  clock; all state changes on the rising edge
- reset_L  in  1  reset; asynchronous, active-low
- in_val  in  N_PORTS  per-port beat valid
- in_sop  in  N_PORTS  per-port start of packet
- in_eop  in  N_PORTS  per-port end of packet
- in_vbc  in  N_PORTS*VBC_W  per-port valid byte count; port i at [i*VBC_W +: VBC_W]
- in_data  in  N_PORTS*DATA_W  per-port data; port i at [i*DATA_W +: DATA_W]
- in_ready  out  N_PORTS  per-port accept
- cfg_port_en  in  N_PORTS  port enable; only affects new grants
- val, sop, eop  out  1  beat qualifiers to the unpacker
- vbc  out  VBC_W  to the unpacker
- data  out  DATA_W  to the unpacker
- ready  in  1  unpacker accept
- grant  out  N_PORTS  one-hot owner; 0 when idle
- idle  out  1  1 when no packet is in progress
- err  out  1  one-cycle pulse on a protocol violation

## Operation
- FSM states: IDLE and BUSY. The registered state is grant, the rr_ptr (0..N_PORTS-1) and err.
- A port is eligible when cfg_port_en[i] & in_val[i] & in_sop[i].
- IDLE: select the first eligible port scanning from rr_ptr upward, wrapping modulo N_PORTS.
  - If a port is found, register grant = one-hot(i) and go to BUSY.
  - If none is found, stay in IDLE.
  - No beat is accepted in IDLE: all in_ready = 0 and val = 0.
- BUSY with owner g:
  - val/sop/eop/vbc/data follow port g combinationally.
  - in_ready[g] = ready; all other in_ready = 0.
  - A beat transfers when val & ready.
- Transferred beat with eop = 1: go to IDLE, clear grant, set rr_ptr = (g+1) mod N_PORTS.
- Transferred beat without eop: stay in BUSY.
- Outputs when not BUSY: val/sop/eop = 0, vbc = 0, data = 0.
- Clearing cfg_port_en[g] mid-packet does not abort the packet. The packet completes, and the port is excluded from later grants.
- A stalled owner (in_val[g] = 0) holds the grant indefinitely; there is no timeout.
- err is registered and pulses 1 cycle after a transferred beat that has any of:
  - sop = 1 on a non-first beat of the packet;
  - vbc = 0;
  - vbc > MAX_VBC;
  - eop = 0 with vbc != MAX_VBC.
- An errored beat is still forwarded, and state advances normally.
- A port presenting val without sop while in IDLE is never granted and waits. No err is raised for it.
- Reset: state = IDLE, grant = 0, rr_ptr = 0, err = 0, idle = 1, in_ready = 0, val = 0. A packet in flight at reset is dropped.

## Timing
- Arbitration latency: 1 cycle. Eligible in IDLE at edge k gives grant/BUSY after edge k, and the first beat can transfer at edge k+1.
- Minimum spacing between packets: 1 idle cycle after the eop transfer, so a single-beat packet costs 2 cycles.
- Multi-beat packets stream at 1 beat/cycle while in_val[g] & ready.
- in_ready, val, sop, eop, vbc and data are combinational from grant plus the inputs. There is no extra register stage.
- idle is high exactly when grant == 0.
- Simultaneous requests in IDLE are resolved by rr_ptr alone. Requests arriving mid-packet wait for the eop.

## Test plan
- Single port: port 0 sends sop&eop, vbc = 32 -> grant = 0001 one cycle later; val/sop/eop = 1 and vbc = 32 on the unpacker side for 1 cycle; idle returns to 1; rr_ptr = 1.
- Fairness: all 4 ports continuously request single-beat packets from reset.
  - Grants go 0,1,2,3,0,1,… with one idle cycle between grants.
  - Each port gets 4 packets in 32 cycles.
- Multi-beat with backpressure: port 2 sends 160/160/159 (eop on the last) while port 1 requests from cycle 1, and ready is low for 3 cycles mid-packet.
  - All 3 beats transfer in order.
  - in_ready[1] stays 0 until after port 2's eop.
  - Port 1 is granted next.
- Disable mid-packet: clear cfg_port_en[2] after port 2's first beat -> the packet completes; later requests from port 2 are never granted while ports 0/1/3 are served.
- Errors: a second beat with sop = 1 gives one err pulse. Non-eop vbc = 100, vbc = 0 and vbc = 200 each give one err pulse. All of these beats are still forwarded.
- Reset mid-packet: assert reset_L = 0 during beat 2 of 3 -> grant = 0, val = 0, in_ready = 0 immediately; after release the arbiter restarts with rr_ptr = 0.
